// File: rtl/udm_splitbus_pkg.sv
// Shared constants, response-entry type and byte-merge helper for the UDM split-transaction bus.
package udm_splitbus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  typedef logic [BUS_DW-1:0] resp_entry_t;

  // Merge new_w into old_w byte by byte; a clear enable keeps the old byte.
  function automatic logic [BUS_DW-1:0] be_merge(input logic [BUS_DW-1:0]  old_w,
                                                 input logic [BUS_DW-1:0]  new_w,
                                                 input logic [BUS_BEW-1:0] be);
    logic [BUS_DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BUS_BEW; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/udm_splitbus_fifo.sv
// Response queue: power-of-2 depth, pointers carry one extra wrap bit to tell full from empty.
module udm_splitbus_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] store [0:DEPTH-1];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = store[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A push on a full queue only happens alongside a pop, so it reuses the slot being vacated.
  always_ff @(posedge clk_i) begin
    if (push) store[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/udm_splitbus_responder.sv
// Split-bus target: word RAM, RD_LAT read pipeline, in-order response FIFO with credit-limited reads.
// Optional macro UDM_SPLITBUS_RESP_JITTER_EN gates response pops with an LFSR to create random gaps.
module udm_splitbus_responder
  import udm_splitbus_pkg::*;
#(
  parameter int          ADDR_W          = 10,
  parameter int          RD_LAT          = 2,
  parameter int          RESP_FIFO_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               bus_req_i,
  input  logic               bus_we_i,
  input  logic [BUS_AW-1:0]  bus_addr_bi,
  input  logic [BUS_BEW-1:0] bus_be_bi,
  input  logic [BUS_DW-1:0]  bus_wdata_bi,
  output logic               bus_ack_o,
  output logic               bus_resp_o,
  output logic [BUS_DW-1:0]  bus_rdata_bo
);

  localparam int CNT_W = $clog2(RESP_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESP_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_bits;
  logic [CNT_W-1:0]  outst_cnt;
  logic              cmd_wr;
  logic              cmd_rd;
  logic              pop_en;
  logic              fifo_empty;
  logic              unused_fifo_full;
  resp_entry_t       fifo_head;

  logic [BUS_DW-1:0] ram [0:(1<<ADDR_W)-1];
  logic [RD_LAT-1:0] pipe_vld;
  resp_entry_t       pipe_data [0:RD_LAT-1];

  assign word_idx         = bus_addr_bi[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus_addr_bi[BUS_AW-1:ADDR_W+2], bus_addr_bi[1:0]};

  // Handshake: a command transfers in every cycle with req & ack; the initiator holds all command
  // fields until ack. resp is a one-cycle valid with no ready, so every pushed entry must pop unaided.
  // Reads need a free credit counted from the registered outst_cnt; writes never wait.
  assign bus_ack_o = bus_req_i & ~rst_i & (bus_we_i | (outst_cnt < CNT_MAX));
  assign cmd_wr    = bus_ack_o & bus_we_i;
  assign cmd_rd    = bus_ack_o & ~bus_we_i;

  always_ff @(posedge clk_i) begin
    if (cmd_wr) ram[word_idx] <= be_merge(ram[word_idx], bus_wdata_bi, bus_be_bi);
    pipe_data[0] <= ram[word_idx];
    for (int i = 1; i < RD_LAT; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= cmd_rd;
      for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  udm_splitbus_fifo #(
    .DEPTH (RESP_FIFO_DEPTH),
    .WIDTH ($bits(resp_entry_t))
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (pipe_vld[RD_LAT-1]),
    .push_data (pipe_data[RD_LAT-1]),
    .pop       (bus_resp_o),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign bus_resp_o   = ~fifo_empty & pop_en;
  assign bus_rdata_bo = bus_resp_o ? fifo_head : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_cnt <= '0;
    end else begin
      case ({cmd_rd, bus_resp_o})
        2'b10:   outst_cnt <= outst_cnt + CNT_ONE;
        2'b01:   outst_cnt <= outst_cnt - CNT_ONE;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

`ifdef UDM_SPLITBUS_RESP_JITTER_EN
  // Right-shifting Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign pop_en = lfsr[0];
`else
  logic unused_seed;

  assign unused_seed = ^LFSR_SEED;
  assign pop_en      = 1'b1;
`endif

endmodule

// File: tb/tb_udm_splitbus_responder.sv
// Randomised scoreboard bench for udm_splitbus_responder against a word-array memory model.
module tb_udm_splitbus_responder;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr  = '0;
  logic [3:0]  be    = '0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  udm_splitbus_responder #(
    .ADDR_W          (ADDR_W),
    .RD_LAT          (RD_LAT),
    .RESP_FIFO_DEPTH (DEPTH),
    .LFSR_SEED       (16'hACE1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus_req_i    (req),
    .bus_we_i     (we),
    .bus_addr_bi  (addr),
    .bus_be_bi    (be),
    .bus_wdata_bi (wdata),
    .bus_ack_o    (ack),
    .bus_resp_o   (resp),
    .bus_rdata_bo (rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] model_mem [0:(1<<ADDR_W)-1];
  int          errors = 0;
  int          checks = 0;
  int          rd_acked = 0;
  int          resp_total = 0;
  bit          resp_now = 1'b0;
  logic [31:0] mon_exp;
  int          mon_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    resp_now = resp;
    if (resp === 1'b1) begin
      resp_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp with rdata 0x%08h, expected none (cycle %0d)", rdata, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("rdata", rdata, mon_exp);
`ifdef UDM_SPLITBUS_RESP_JITTER_EN
        checks++;
        if (cyc < mon_cyc) begin
          errors++;
          $display("FAIL resp_latency: resp in cycle %0d, required not before %0d", cyc, mon_cyc);
        end
`else
        check("resp_latency", 32'(cyc), 32'(mon_cyc));
`endif
      end
    end else begin
      check("rdata_idle_zero", rdata, 32'h0);
    end
  end

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int  idx;
    bit  exp_ack;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    for (int n = 0; n < 300; n++) begin
      #1;
      exp_ack = w || ((rd_acked - (resp_total - int'(resp_now))) < DEPTH);
      check("ack", {31'b0, ack}, {31'b0, exp_ack});
      if (ack === 1'b1) begin
        idx = int'(a[ADDR_W+1:2]);
        if (w) begin
          for (int k = 0; k < 4; k++) if (b[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
        end else begin
          exp_q.push_back(model_mem[idx]);
          exp_cyc_q.push_back(cyc + RD_LAT + 1);
          rd_acked++;
        end
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: no ack for addr 0x%08h we %0d", a, w);
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    req = 1'b0;
    for (int n = 0; n < 600 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ra;
  int          word;

  initial begin
    // Reset state, including a held write request that must not be acked.
    req = 1'b1; we = 1'b1;
    #2;
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_resp", {31'b0, resp}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    req = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Full write then read-back with exact latency.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    drain();

    // Partial-byte write merge: expect 0x11BB33DD.
    issue(1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    issue(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    drain();

    // Back-to-back reads beyond the credit limit.
    for (int i = 0; i < 5; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'(i + 1));
    idle(1);
    for (int i = 0; i < 5; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
    drain();

    // Write accepted while reads are out of credits, then read it behind them.
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
    issue(1'b1, 32'h100, 4'hF, 32'h5A5A1234);
    issue(1'b0, 32'h100, 4'h0, 32'h0);
    issue(1'b0, 32'h0, 4'h0, 32'h0);
    drain();

    // Reset with reads in flight, one response on the bus.
    issue(1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
    idle(1);
    for (int i = 0; i < 3; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
    req = 1'b1; we = 1'b0; addr = 32'h8;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'h0);
    check("midrst_resp", {31'b0, resp}, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    exp_q.delete();
    exp_cyc_q.delete();
    rd_acked = 0;
    resp_total = 0;
    req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(15);
    for (int i = 0; i < DEPTH - 1; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
    issue(1'b0, 32'h40, 4'h0, 32'h0);
    drain();

    // Randomised mix over 16 words with random aliasing bits.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'((128 + i) * 4), 4'hF, $urandom);
    for (int n = 0; n < 200; n++) begin
      word = 128 + $urandom_range(0, 15);
      ra   = ($urandom << (ADDR_W + 2)) | 32'(word << 2) | 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    check("resp_count", 32'(resp_total), 32'(rd_acked));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
